// File: rtl/video_mem_arbiter_if.sv
// Port bundle between the video RAM arbiter and its clients: video fetch, Z80 bus and RAM port.
interface video_mem_arbiter_if;
  logic        pix_stb;
  logic        vid_en;
  logic [16:0] vid_addr;
  logic [7:0]  vid_din;

  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;

  logic [16:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  pix_stb, vid_en, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vid_din, cpu_rdata, cpu_ack, cpu_busy,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output pix_stb, vid_en, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vid_din, cpu_rdata, cpu_ack, cpu_busy,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/video_mem_arbiter.sv
// Shares one RAM port between hard-slotted video fetches (pix_stb cycle) and a one-entry CPU request path.
//
// state    | meaning
// S_IDLE   | no CPU request held, cpu_busy=0, accepts cpu_req
// S_PEND   | request latched in holding reg, waiting for a free slot
// S_FLIGHT | access issued, waiting for cpu_ack (read data or write done)
module video_mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input logic             i_clk_sys,
  input logic             i_reset,
  video_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_FLIGHT = 2'd2
  } cpu_state_t;

  cpu_state_t r_state;
  cpu_state_t w_state_nxt;

  logic [1:0]  r_cnt;
  logic [1:0]  w_ph;

  logic        r_hold_we;
  logic [16:0] r_hold_addr;
  logic [7:0]  r_hold_wdata;

  logic        w_accept;
  logic        w_vid_issue;
  logic        w_cpu_issue;

  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_rd_is_vid;
  logic [16:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;

  logic [MEM_LAT-1:0] r_tag_vld;
  logic [MEM_LAT-1:0] r_tag_vid;
  logic        w_exit_vld;
  logic        w_exit_vid;

  logic [7:0]  r_vid_din;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_ack;

  // Slot phase is 0 in the pix_stb cycle itself, so the registered part starts at 1 after it.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= 2'd3;
    end else if (bus.pix_stb) begin
      r_cnt <= 2'd1;
    end else if (r_cnt != 2'd3) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign w_ph        = bus.pix_stb ? 2'd0 : r_cnt;
  assign w_vid_issue = bus.pix_stb & bus.vid_en;

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cpu_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        // Video owns ph==0; with video enabled the CPU gets the fixed ph==2 slot.
        if (bus.vid_en ? (w_ph == 2'd2) : !w_vid_issue) begin
          w_cpu_issue = 1'b1;
          w_state_nxt = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (r_cpu_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_hold_we    <= 1'b0;
      r_hold_addr  <= 17'd0;
      r_hold_wdata <= 8'd0;
    end else if (w_accept) begin
      r_hold_we    <= bus.cpu_we;
      r_hold_addr  <= bus.cpu_addr;
      r_hold_wdata <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_rd_is_vid <= 1'b0;
      r_mem_addr  <= 17'd0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_mem_rd    <= w_vid_issue | (w_cpu_issue & ~r_hold_we);
      r_mem_wr    <= w_cpu_issue & r_hold_we;
      r_rd_is_vid <= w_vid_issue;
      if (w_vid_issue) begin
        r_mem_addr <= bus.vid_addr;
      end else if (w_cpu_issue) begin
        r_mem_addr <= r_hold_addr;
      end
      if (w_cpu_issue & r_hold_we) begin
        r_mem_wdata <= r_hold_wdata;
      end
    end
  end

  // Tag enters alongside the mem_rd strobe so its last stage lines up with valid mem_rdata.
  generate
    if (MEM_LAT == 1) begin : g_tag_lat1
      always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
          r_tag_vld <= '0;
          r_tag_vid <= '0;
        end else begin
          r_tag_vld <= r_mem_rd;
          r_tag_vid <= r_rd_is_vid;
        end
      end
    end else begin : g_tag_latn
      always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
          r_tag_vld <= '0;
          r_tag_vid <= '0;
        end else begin
          r_tag_vld <= {r_tag_vld[MEM_LAT-2:0], r_mem_rd};
          r_tag_vid <= {r_tag_vid[MEM_LAT-2:0], r_rd_is_vid};
        end
      end
    end
  endgenerate

  assign w_exit_vld = r_tag_vld[MEM_LAT-1];
  assign w_exit_vid = r_tag_vid[MEM_LAT-1];

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_vid_din   <= 8'd0;
      r_cpu_rdata <= 8'd0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= (w_exit_vld & ~w_exit_vid) | r_mem_wr;
      if (w_exit_vld & w_exit_vid) begin
        r_vid_din <= bus.mem_rdata;
      end
      if (w_exit_vld & ~w_exit_vid) begin
        r_cpu_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.vid_din   = r_vid_din;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_busy  = (r_state != S_IDLE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench: MEM_LAT=1 instance (video, CPU read/write, tie, reset) and MEM_LAT=2 instance (pipelined periods).
module tb_video_mem_arbiter;
  logic clk_sys;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  video_mem_arbiter_if a1();
  video_mem_arbiter_if a2();

  video_mem_arbiter #(.MEM_LAT(1)) dut1 (.i_clk_sys(clk_sys), .i_reset(rst), .bus(a1.slave));
  video_mem_arbiter #(.MEM_LAT(2)) dut2 (.i_clk_sys(clk_sys), .i_reset(rst), .bus(a2.slave));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] ram_init(input logic [16:0] a);
    case (a)
      17'h01234: ram_init = 8'hA5;
      17'h1FFFF: ram_init = 8'h3C;
      default:   ram_init = a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
    endcase
  endfunction

  logic [7:0] ram1 [logic [16:0]];
  always @(posedge clk_sys) begin
    if (a1.mem_wr) ram1[a1.mem_addr] = a1.mem_wdata;
    if (a1.mem_rd) a1.mem_rdata <= ram1.exists(a1.mem_addr) ? ram1[a1.mem_addr] : ram_init(a1.mem_addr);
  end

  logic [7:0] r2_stage;
  always @(posedge clk_sys) begin
    if (a2.mem_rd) r2_stage <= ram_init(a2.mem_addr);
    a2.mem_rdata <= r2_stage;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    a1.pix_stb = (cyc % 4 == 0);
    a2.pix_stb = (cyc % 4 == 0);
  endtask

  task automatic to_ph(input int n);
    for (int i = 0; i < 4 && (cyc % 4) != n; i++) step();
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_vid_din"},   a1.vid_din,   0);
    chk({pfx, "_cpu_rdata"}, a1.cpu_rdata, 0);
    chk({pfx, "_cpu_ack"},   a1.cpu_ack,   0);
    chk({pfx, "_cpu_busy"},  a1.cpu_busy,  0);
    chk({pfx, "_mem_rd"},    a1.mem_rd,    0);
    chk({pfx, "_mem_wr"},    a1.mem_wr,    0);
    chk({pfx, "_mem_addr"},  a1.mem_addr,  0);
    chk({pfx, "_mem_wdata"}, a1.mem_wdata, 0);
    chk({pfx, "_dut2_vid"},  a2.vid_din,   0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 1;
    rst = 1'b1;
    a1.pix_stb = 0; a1.vid_en = 0; a1.vid_addr = '0; a1.cpu_req = 0; a1.cpu_we = 0; a1.cpu_addr = '0; a1.cpu_wdata = '0;
    a2.pix_stb = 0; a2.vid_en = 0; a2.vid_addr = '0; a2.cpu_req = 0; a2.cpu_we = 0; a2.cpu_addr = '0; a2.cpu_wdata = '0;
    step(); step();
    chk_rst("por");
    rst = 1'b0;
    step();

    // Video fetch, MEM_LAT=1
    to_ph(0);
    a1.vid_en = 1; a1.vid_addr = 17'h01234;
    step();
    chk("vid_mem_rd", a1.mem_rd, 1);
    chk("vid_mem_addr", a1.mem_addr, 17'h01234);
    chk("vid_no_wr", a1.mem_wr, 0);
    a1.vid_addr = 17'h00003;
    step();
    chk("vid_din_early", a1.vid_din, 0);
    step();
    chk("vid_din_a5", a1.vid_din, 8'hA5);
    step();
    chk("vid_din_hold_pix", a1.vid_din, 8'hA5);
    step(); step();
    chk("vid_din_hold", a1.vid_din, 8'hA5);
    step();
    chk("vid_din_next", a1.vid_din, 8'h03);

    // CPU read under video, raised at ph=3
    a1.cpu_req = 1; a1.cpu_we = 0; a1.cpu_addr = 17'h1FFFF;
    step();
    a1.cpu_req = 0;
    chk("rd_busy_set", a1.cpu_busy, 1);
    step();
    chk("rd_vid_slot_addr", a1.mem_addr, 17'h00003);
    step();
    chk("rd_wait_ph2", a1.mem_rd, 0);
    step();
    chk("rd_issue", a1.mem_rd, 1);
    chk("rd_issue_addr", a1.mem_addr, 17'h1FFFF);
    step();
    chk("rd_ack_early", a1.cpu_ack, 0);
    step();
    chk("rd_ack", a1.cpu_ack, 1);
    chk("rd_data", a1.cpu_rdata, 8'h3C);
    chk("rd_busy_in_ack", a1.cpu_busy, 1);
    step();
    chk("rd_ack_pulse", a1.cpu_ack, 0);
    chk("rd_busy_clr", a1.cpu_busy, 0);
    chk("rd_data_hold", a1.cpu_rdata, 8'h3C);

    // CPU write at ph=1
    to_ph(1);
    a1.cpu_req = 1; a1.cpu_we = 1; a1.cpu_addr = 17'h00010; a1.cpu_wdata = 8'h5A;
    step();
    a1.cpu_req = 0;
    chk("wr_not_yet", a1.mem_wr, 0);
    step();
    chk("wr_pulse", a1.mem_wr, 1);
    chk("wr_addr", a1.mem_addr, 17'h00010);
    chk("wr_wdata", a1.mem_wdata, 8'h5A);
    chk("wr_no_rd", a1.mem_rd, 0);
    step();
    chk("wr_single", a1.mem_wr, 0);
    chk("wr_ack", a1.cpu_ack, 1);
    chk("wr_rdata_kept", a1.cpu_rdata, 8'h3C);
    step();
    chk("wr_busy_clr", a1.cpu_busy, 0);
    a1.vid_addr = 17'h00010;
    step(); step(); step(); step(); step();
    chk("wr_vid_old", a1.vid_din, 8'h03);
    step();
    chk("wr_vid_readback", a1.vid_din, 8'h5A);

    // Tie: request held while vid_en rises on the pix_stb cycle
    a1.vid_en = 0;
    to_ph(3);
    a1.cpu_req = 1; a1.cpu_we = 0; a1.cpu_addr = 17'h00020; a1.vid_addr = 17'h00007;
    step();
    a1.cpu_req = 0; a1.vid_en = 1;
    chk("tie_idle", a1.mem_rd, 0);
    step();
    chk("tie_vid_first", a1.mem_rd, 1);
    chk("tie_vid_addr", a1.mem_addr, 17'h00007);
    chk("tie_overlap_a", a1.mem_rd & a1.mem_wr, 0);
    step();
    chk("tie_gap", a1.mem_rd, 0);
    step();
    chk("tie_cpu_ph2", a1.mem_rd, 1);
    chk("tie_cpu_addr", a1.mem_addr, 17'h00020);
    chk("tie_vid_din", a1.vid_din, 8'h07);
    chk("tie_overlap_b", a1.mem_rd & a1.mem_wr, 0);
    step(); step();
    chk("tie_ack", a1.cpu_ack, 1);
    chk("tie_rdata", a1.cpu_rdata, 8'h20);
    a1.vid_en = 0;

    // Reset with a CPU read in flight
    step();
    a1.cpu_req = 1; a1.cpu_we = 0; a1.cpu_addr = 17'h00005;
    step();
    a1.cpu_req = 0;
    step();
    chk("inflt_issue", a1.mem_rd, 1);
    chk("inflt_addr", a1.mem_addr, 17'h00005);
    step();
    rst = 1'b1;
    #1;
    chk_rst("midrst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_ack_after_rst", a1.cpu_ack, 0);
    end
    chk("no_rdata_after_rst", a1.cpu_rdata, 0);

    // MEM_LAT=2: back-to-back video periods with CPU reads
    to_ph(0);
    a2.vid_en = 1; a2.vid_addr = 17'h00011;
    step();
    a2.cpu_req = 1; a2.cpu_we = 0; a2.cpu_addr = 17'h00055;
    step();
    a2.cpu_req = 0;
    step();
    chk("l2_cpu_issue", a2.mem_rd, 1);
    chk("l2_cpu_addr", a2.mem_addr, 17'h00055);
    step();
    chk("l2_vid_p0", a2.vid_din, 8'h11);
    a2.vid_addr = 17'h10022;
    step();
    chk("l2_no_leak", a2.cpu_rdata, 0);
    step();
    chk("l2_ack_a", a2.cpu_ack, 1);
    chk("l2_rdata_a", a2.cpu_rdata, 8'h55);
    chk("l2_vid_kept_a", a2.vid_din, 8'h11);
    step();
    chk("l2_busy_clr", a2.cpu_busy, 0);
    step();
    chk("l2_vid_p1", a2.vid_din, 8'h23);
    a2.vid_addr = 17'h00033;
    step();
    a2.cpu_req = 1; a2.cpu_addr = 17'h00066;
    step();
    a2.cpu_req = 0;
    step(); step();
    chk("l2_vid_p2", a2.vid_din, 8'h33);
    a2.vid_addr = 17'h00044;
    step(); step();
    chk("l2_ack_b", a2.cpu_ack, 1);
    chk("l2_rdata_b", a2.cpu_rdata, 8'h66);
    chk("l2_vid_kept_b", a2.vid_din, 8'h33);
    step(); step();
    chk("l2_vid_p3", a2.vid_din, 8'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
